alu_axi_lite_slave: RTL

AXI4-Lite responder that lets the PS-side AXI master drive one user ALU through memory-mapped registers instead of GPIO. It holds the A, B and ALUop operands and drives them into a combinational user ALU. On a start command it waits a programmable settle time, then captures Result and the three flags into read-only registers. It sits between a `mips*_cpu_axi_if` master port and one `userN` ALU instance.

---
 rtl/alu_axi_pkg.sv | 46 ++++
 rtl/alu_axi_lite_slave_wr_join.sv | 77 +++++++
 rtl/alu_axi_lite_slave.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_axi_pkg.sv
// alu_axi_pkg
// Shared definitions for the AXI4-Lite ALU register slice: register byte
// offsets and their word indices, AXI response codes, STATUS bit positions,
// the sequencing FSM state type and a byte-strobe merge helper.
package alu_axi_pkg;

    localparam logic [4:0] OFF_A      = 5'h00;
    localparam logic [4:0] OFF_B      = 5'h04;
    localparam logic [4:0] OFF_OP     = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [4:0] OFF_RESULT = 5'h14;

    // Only address bits [4:2] are decoded, so registers are matched on word index.
    localparam logic [2:0] IDX_A      = OFF_A[4:2];
    localparam logic [2:0] IDX_B      = OFF_B[4:2];
    localparam logic [2:0] IDX_OP     = OFF_OP[4:2];
    localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
    localparam logic [2:0] IDX_RESULT = OFF_RESULT[4:2];

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned STATUS_DONE  = 0;
    localparam int unsigned STATUS_ZERO  = 1;
    localparam int unsigned STATUS_CARRY = 2;
    localparam int unsigned STATUS_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                 input logic [31:0] data,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_axi_lite_slave_wr_join.sv
// axi_lite_wr_join
// Joins the independent AXI4-Lite AW and W channels. Each channel owns a
// one-entry buffer; once both hold data a single-cycle commit pulse is issued
// and the response supplied by the register decode is latched onto B. Both
// buffers are released on the B handshake, so at most one write is in flight.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axi_aw*/w*/b*           AXI4-Lite write address, data and response
//   commit                    one-cycle write strobe to the register file
//   wr_addr/wr_data/wr_strb   buffered write transaction, valid with commit
//   wr_resp                   decode result, sampled with commit
module axi_lite_wr_join #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic                  commit,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb,
    input  logic [1:0]            wr_resp
);

    logic out_of_reset;
    logic aw_full;
    logic w_full;

    // Readies are held low for the reset cycle and rise on the first cycle after.
    assign s_axi_awready = out_of_reset & ~aw_full;
    assign s_axi_wready  = out_of_reset & ~w_full;
    assign commit        = aw_full & w_full & ~s_axi_bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_of_reset <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_strb      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            out_of_reset <= 1'b1;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_full <= 1'b1;
                wr_addr <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_full  <= 1'b1;
                wr_data <= s_axi_wdata;
                wr_strb <= s_axi_wstrb;
            end
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_resp;
            end
            // Buffers cannot be refilled while full, so this never races the loads above.
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_axi_lite_slave.sv
// alu_axi_lite_slave
// AXI4-Lite register front end for one combinational user ALU. Holds the A, B
// and OP operands (driven straight onto alu_A/alu_B/alu_op), and on a start
// command waits SETTLE_CYCLES for the ALU to settle before capturing Result
// and the Zero/CarryOut/Overflow flags into read-only registers.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axi_*                   AXI4-Lite slave (awprot/arprot ignored)
//   alu_A, alu_B, alu_op      operands to the user ALU
//   alu_Result, alu_Zero,
//   alu_CarryOut, alu_Overflow  results from the user ALU
//   irq                       done & CTRL[1], registered (only with ALU_AXI_IRQ_EN)
// Optional feature macro: ALU_AXI_IRQ_EN
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a start write; operands writable
// ST_SETTLE  | operands frozen, counter runs down to 0
// ST_CAPTURE | latch Result and flags, set done, return to idle
module alu_axi_lite_slave
    import alu_axi_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ALU_AXI_IRQ_EN
    output logic                  irq,
`endif
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           alu_A,
    output logic [31:0]           alu_B,
    output logic [2:0]            alu_op,
    input  logic [31:0]           alu_Result,
    input  logic                  alu_Zero,
    input  logic                  alu_CarryOut,
    input  logic                  alu_Overflow
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [1:0]            wr_resp;
    logic [2:0]            wr_idx;
    logic [2:0]            rd_idx;

    logic [31:0] reg_a, reg_b, result;
    logic [2:0]  reg_op;
    logic        done, flag_zero, flag_carry, flag_ovf;
    logic        irq_en_bit;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        busy, start, capture, start_req, clr_done, reg_wr;

    logic        rd_out_of_reset;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                           wr_addr[ADDR_WIDTH-1:5], wr_addr[1:0],
                           s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

    axi_lite_wr_join #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_join (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .commit        (wr_commit),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_resp       (wr_resp)
    );

    assign alu_A  = reg_a;
    assign alu_B  = reg_b;
    assign alu_op = reg_op;

    assign busy   = (state != ST_IDLE);
    assign wr_idx = wr_addr[4:2];
    assign rd_idx = s_axi_araddr[4:2];

    // Operand writes are refused while the ALU inputs must stay frozen.
    always_comb begin
        wr_resp = RESP_SLVERR;
        case (wr_idx)
            IDX_A, IDX_B, IDX_OP: wr_resp = busy ? RESP_SLVERR : RESP_OKAY;
            IDX_CTRL, IDX_STATUS: wr_resp = RESP_OKAY;
            default:              wr_resp = RESP_SLVERR;
        endcase
    end

    assign reg_wr    = wr_commit && (wr_resp == RESP_OKAY);
    assign start_req = wr_commit && (wr_idx == IDX_CTRL) && wr_data[0];
    assign clr_done  = wr_commit && (wr_idx == IDX_STATUS) && wr_data[STATUS_DONE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A start arriving outside ST_IDLE is simply not looked at.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    start    = 1'b1;
                    cnt_nx   = SETTLE_LOAD;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) state_nx = ST_CAPTURE;
                else             cnt_nx   = cnt - 4'd1;
            end
            ST_CAPTURE: begin
                capture  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a      <= 32'h0;
            reg_b      <= 32'h0;
            reg_op     <= 3'd0;
            result     <= 32'h0;
            done       <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (wr_idx)
                    IDX_A:   reg_a  <= apply_wstrb(reg_a, wr_data, wr_strb);
                    IDX_B:   reg_b  <= apply_wstrb(reg_b, wr_data, wr_strb);
                    IDX_OP:  reg_op <= wr_strb[0] ? wr_data[2:0] : reg_op;
                    default: ;
                endcase
            end
            // Capture outranks a same-edge clear so a finished result is never lost.
            if (capture) begin
                done       <= 1'b1;
                result     <= alu_Result;
                flag_zero  <= alu_Zero;
                flag_carry <= alu_CarryOut;
                flag_ovf   <= alu_Overflow;
            end else if (start || clr_done) begin
                done <= 1'b0;
            end
        end
    end

`ifdef ALU_AXI_IRQ_EN
    logic irq_en;
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_commit && (wr_idx == IDX_CTRL)) irq_en <= wr_data[1];
            irq <= done & irq_en;
        end
    end
    assign irq_en_bit = irq_en;
`else
    assign irq_en_bit = 1'b0;
`endif

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            IDX_A:      rd_data = reg_a;
            IDX_B:      rd_data = reg_b;
            IDX_OP:     rd_data = {29'h0, reg_op};
            IDX_CTRL:   rd_data = {30'h0, irq_en_bit, busy};
            IDX_STATUS: rd_data = {28'h0, flag_ovf, flag_carry, flag_zero, done};
            IDX_RESULT: rd_data = result;
            default:    rd_resp = RESP_SLVERR;
        endcase
    end

    assign s_axi_arready = rd_out_of_reset & ~s_axi_rvalid;

    // Sampling here at the handshake edge means a same-edge write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_out_of_reset <= 1'b0;
            s_axi_rvalid    <= 1'b0;
            s_axi_rdata     <= 32'h0;
            s_axi_rresp     <= 2'b00;
        end else begin
            rd_out_of_reset <= 1'b1;
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_resp;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule
